// File: rtl/pc_stage_ras.sv
// Fetch-stage PC register with next-PC select, DEPTH-entry return-address stack and IorD address mux.
// Optional: define PC_ALIGN_CHECK_EN to add the misalign output and block odd next-PC loads.
module pc_stage_ras #(
    parameter int               WIDTH    = 16,
    parameter int               DEPTH    = 4,
    parameter int               PC_INC   = 2,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             pc_w,
    input  logic [1:0]       pcsrc,
    input  logic             push,
    input  logic             err_clr,
    input  logic [WIDTH-1:0] alu_in,
    input  logic [WIDTH-1:0] mdr_in,
    input  logic [WIDTH-1:0] aluout_in,
    input  logic [WIDTH-1:0] imm_in,
    input  logic [WIDTH-1:0] mem_in,
    input  logic [1:0]       iord,
    output logic [WIDTH-1:0] iord_out,
    output logic [WIDTH-1:0] pc_out,
    output logic             ras_empty,
    output logic             ras_full,
`ifdef PC_ALIGN_CHECK_EN
    output logic             misalign,
`endif
    output logic             ras_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        SRC_INC = 2'd0,
        SRC_ALU = 2'd1,
        SRC_MDR = 2'd2,
        SRC_RAS = 2'd3
    } pcsrc_e;

    typedef enum logic [1:0] {
        ADR_PC     = 2'd0,
        ADR_ALUOUT = 2'd1,
        ADR_IMM    = 2'd2,
        ADR_MEM    = 2'd3
    } iord_e;

    logic [WIDTH-1:0] ras_mem [DEPTH];
    logic [CW-1:0]    count;
    logic [AW-1:0]    push_idx;
    logic [AW-1:0]    top_idx;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] ras_top;
    logic [WIDTH-1:0] next_pc;

    logic pop_req;
    logic push_req;
    logic pop_empty;
    logic push_full;
    logic hold;
    logic do_pop;
    logic do_push;
    logic do_swap;
    logic load_pc;
    logic err_set;

    assign pc_inc    = pc_out + WIDTH'(PC_INC);
    assign ras_empty = (count == '0);
    assign ras_full  = (count == CW'(DEPTH));

    // With DEPTH a power of two, the low bits of count index the next free slot and wrap cleanly for the top.
    assign push_idx = count[AW-1:0];
    assign top_idx  = push_idx - AW'(1);
    assign ras_top  = ras_mem[top_idx];

    assign pop_req   = pc_w && (pcsrc == SRC_RAS);
    assign push_req  = pc_w && push;
    assign pop_empty = pop_req && ras_empty;
    assign push_full = push_req && !pop_req && ras_full;

    // NOTE: every always_comb output gets a default before the case so no path can infer a latch.
    always_comb begin
        next_pc = pc_inc;
        unique case (pcsrc_e'(pcsrc))
            SRC_INC: next_pc = pc_inc;
            SRC_ALU: next_pc = alu_in;
            SRC_MDR: next_pc = mdr_in;
            SRC_RAS: next_pc = pop_empty ? pc_out : ras_top;
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    assign misalign = pc_w && next_pc[0];
    assign hold     = misalign;
`else
    assign hold     = 1'b0;
`endif

    assign do_pop  = pop_req && !ras_empty && !push && !hold;
    assign do_swap = pop_req && !ras_empty && push && !hold;
    assign do_push = push_req && !pop_req && !ras_full && !hold;
    assign load_pc = pc_w && !pop_empty && !hold;
    assign err_set = (pop_empty || push_full) && !hold;

    always_comb begin
        iord_out = pc_out;
        unique case (iord_e'(iord))
            ADR_PC:     iord_out = pc_out;
            ADR_ALUOUT: iord_out = aluout_in;
            ADR_IMM:    iord_out = imm_in;
            ADR_MEM:    iord_out = mem_in;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            pc_out  <= RESET_PC;
            count   <= '0;
            ras_err <= 1'b0;
        end else begin
            if (load_pc) begin
                pc_out <= next_pc;
            end
            if (do_push) begin
                count <= count + CW'(1);
            end else if (do_pop) begin
                count <= count - CW'(1);
            end
            if (err_set) begin
                ras_err <= 1'b1;
            end else if (err_clr) begin
                ras_err <= 1'b0;
            end
        end
    end

    // NOTE: stack entries carry no reset; clearing count is enough to make them unreachable.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            ras_mem[push_idx] <= pc_inc;
        end else if (do_swap) begin
            ras_mem[top_idx] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_pc_stage_ras.sv
// Scoreboard bench for pc_stage_ras: directed stimulus queues expectations, a monitor pops and compares.
// Build with PC_ALIGN_CHECK_EN defined to also exercise the misalign output.
module tb_pc_stage_ras;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        pc_w = 1'b0;
    logic [1:0]  pcsrc = 2'd0;
    logic        push = 1'b0;
    logic        err_clr = 1'b0;
    logic [15:0] alu_in = '0;
    logic [15:0] mdr_in = '0;
    logic [15:0] aluout_in = '0;
    logic [15:0] imm_in = '0;
    logic [15:0] mem_in = '0;
    logic [1:0]  iord = 2'd0;
    logic [15:0] iord_out;
    logic [15:0] pc_out;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_err;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign;
`endif

    pc_stage_ras #(.WIDTH(16), .DEPTH(4), .PC_INC(2), .RESET_PC(16'h0000)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .pc_w      (pc_w),
        .pcsrc     (pcsrc),
        .push      (push),
        .err_clr   (err_clr),
        .alu_in    (alu_in),
        .mdr_in    (mdr_in),
        .aluout_in (aluout_in),
        .imm_in    (imm_in),
        .mem_in    (mem_in),
        .iord      (iord),
        .iord_out  (iord_out),
        .pc_out    (pc_out),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
`ifdef PC_ALIGN_CHECK_EN
        .misalign  (misalign),
`endif
        .ras_err   (ras_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic        empty;
        logic        full;
        logic        err;
        logic        chk_iord;
        logic [15:0] iord;
        logic        chk_mis;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;
    int   vectors = 0;
    int   miscompares = 0;

    // Monitor: drains every pending expectation shortly after a clock edge or a combinational sample request.
    initial begin : monitor
        exp_t e;
        logic bad;
        forever begin
            @(posedge CLK or sample_ev);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                bad = (pc_out !== e.pc) || (ras_empty !== e.empty) ||
                      (ras_full !== e.full) || (ras_err !== e.err) ||
                      (e.chk_iord && (iord_out !== e.iord));
`ifdef PC_ALIGN_CHECK_EN
                if (e.chk_mis && (misalign !== e.mis)) bad = 1'b1;
`endif
                vectors++;
                if (bad) begin
                    miscompares++;
                    $display("FAIL %s: got pc=%h empty=%b full=%b err=%b iord=%h, want pc=%h empty=%b full=%b err=%b iord=%h(chk=%b)",
                             e.name, pc_out, ras_empty, ras_full, ras_err, iord_out,
                             e.pc, e.empty, e.full, e.err, e.iord, e.chk_iord);
                end
            end
        end
    end

    task automatic clk_step(input string name, input logic [15:0] pc,
                            input logic e, input logic f, input logic r);
        exp_t x;
        x.name = name; x.pc = pc; x.empty = e; x.full = f; x.err = r;
        x.chk_iord = 1'b0; x.iord = '0; x.chk_mis = 1'b0; x.mis = 1'b0;
        exp_q.push_back(x);
        @(posedge CLK);
        #2;
        pc_w = 1'b0; pcsrc = 2'd0; push = 1'b0; err_clr = 1'b0;
    endtask

    task automatic comb_check(input string name, input logic [15:0] pc,
                              input logic e, input logic f, input logic r,
                              input logic [15:0] io, input logic chk_mis, input logic mis);
        exp_t x;
        #1;
        x.name = name; x.pc = pc; x.empty = e; x.full = f; x.err = r;
        x.chk_iord = 1'b1; x.iord = io; x.chk_mis = chk_mis; x.mis = mis;
        exp_q.push_back(x);
        -> sample_ev;
        #2;
    endtask

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        repeat (2) @(negedge CLK);
        comb_check("reset_state", 16'h0000, 1, 0, 0, 16'h0000, 0, 0);
        @(negedge CLK);
        reset = 1'b1;

        // Sequential increment, then hold.
        pc_w = 1; clk_step("inc1", 16'h0002, 1, 0, 0);
        pc_w = 1; clk_step("inc2", 16'h0004, 1, 0, 0);
        pc_w = 1; clk_step("inc3", 16'h0006, 1, 0, 0);
        clk_step("hold", 16'h0006, 1, 0, 0);
        comb_check("iord_pc", 16'h0006, 1, 0, 0, 16'h0006, 0, 0);

        // Call / return.
        pc_w = 1; pcsrc = 2'd1; alu_in = 16'h0010; clk_step("ld_alu", 16'h0010, 1, 0, 0);
        pc_w = 1; pcsrc = 2'd1; alu_in = 16'h0100; push = 1; clk_step("call", 16'h0100, 0, 0, 0);
        pc_w = 1; pcsrc = 2'd3; clk_step("ret", 16'h0012, 1, 0, 0);

        // Fill, overflow, then drain in LIFO order.
        for (int i = 0; i < 4; i++) begin
            pc_w = 1; push = 1;
            clk_step("push", 16'h0014 + 16'(2 * i), 0, (i == 3), 0);
        end
        pc_w = 1; push = 1; clk_step("push_ovf", 16'h001C, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            pc_w = 1; pcsrc = 2'd3;
            clk_step("pop", 16'h001A - 16'(2 * i), (i == 3), 0, 1);
        end

        // Underflow and sticky error behaviour.
        err_clr = 1; clk_step("clr1", 16'h0014, 1, 0, 0);
        pc_w = 1; pcsrc = 2'd3; clk_step("pop_empty", 16'h0014, 1, 0, 1);
        clk_step("err_sticky", 16'h0014, 1, 0, 1);
        err_clr = 1; clk_step("clr2", 16'h0014, 1, 0, 0);
        pc_w = 1; pcsrc = 2'd3; err_clr = 1; clk_step("set_wins", 16'h0014, 1, 0, 1);
        err_clr = 1; clk_step("clr3", 16'h0014, 1, 0, 0);
        push = 1; clk_step("push_no_we", 16'h0014, 1, 0, 0);

        // Simultaneous pop+push replaces the top entry.
        pc_w = 1; pcsrc = 2'd1; alu_in = 16'h0010; clk_step("ld10", 16'h0010, 1, 0, 0);
        pc_w = 1; pcsrc = 2'd1; alu_in = 16'h0040; push = 1; clk_step("call40", 16'h0040, 0, 0, 0);
        pc_w = 1; pcsrc = 2'd3; push = 1; clk_step("pop_push", 16'h0012, 0, 0, 0);
        pc_w = 1; pcsrc = 2'd3; clk_step("ret42", 16'h0042, 1, 0, 0);

        // Indirect target and increment wrap.
        pc_w = 1; pcsrc = 2'd2; mdr_in = 16'h0200; clk_step("ld_mdr", 16'h0200, 1, 0, 0);
        pc_w = 1; pcsrc = 2'd1; alu_in = 16'hFFFE; clk_step("ld_fffe", 16'hFFFE, 1, 0, 0);
        pc_w = 1; clk_step("wrap", 16'h0000, 1, 0, 0);

        // Memory address mux.
        aluout_in = 16'h1234; imm_in = 16'h5678; mem_in = 16'h9ABC;
        iord = 2'd1; comb_check("iord_aluout", 16'h0000, 1, 0, 0, 16'h1234, 0, 0);
        iord = 2'd2; comb_check("iord_imm", 16'h0000, 1, 0, 0, 16'h5678, 0, 0);
        iord = 2'd3; comb_check("iord_mem", 16'h0000, 1, 0, 0, 16'h9ABC, 0, 0);
        iord = 2'd0; comb_check("iord_pc0", 16'h0000, 1, 0, 0, 16'h0000, 0, 0);

`ifdef PC_ALIGN_CHECK_EN
        pc_w = 1; pcsrc = 2'd1; alu_in = 16'h0101;
        comb_check("misalign", 16'h0000, 1, 0, 0, 16'h0000, 1, 1);
        pc_w = 1; pcsrc = 2'd1; alu_in = 16'h0101; clk_step("mis_hold", 16'h0000, 1, 0, 0);
`endif

        // Asynchronous reset in the middle of activity.
        pc_w = 1; pcsrc = 2'd3; clk_step("pre_err", 16'h0000, 1, 0, 1);
        pc_w = 1; push = 1; clk_step("pre_push", 16'h0002, 0, 0, 1);
        @(negedge CLK);
        reset = 1'b0;
        comb_check("async_reset", 16'h0000, 1, 0, 0, 16'h0000, 0, 0);
        @(negedge CLK);
        reset = 1'b1;

        repeat (2) @(negedge CLK);
        if (exp_q.size() != 0) begin
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
            miscompares += exp_q.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
